// File: rtl/i2c_master_ctrl_if.sv
// Command, response and open-drain bus signals of i2c_master_ctrl.
// The master modport is the controller side; slave is the requester/bus environment side.
interface i2c_master_ctrl_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_rw;
    logic [3:0] cmd_reg;
    logic [7:0] cmd_wdata;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       rsp_nack;
    logic       busy;
    logic       scl_in;
    logic       sda_in;
    logic       scl_oe;
    logic       sda_oe;

    // Handshake: a command transfers on a rising edge where cmd_valid && cmd_ready;
    // cmd_ready is high only while idle, and rsp_valid is a one-cycle pulse with
    // rsp_rdata/rsp_nack, which then hold until the next pulse. No back-pressure on rsp.
    modport master (
        input  cmd_valid, cmd_rw, cmd_reg, cmd_wdata, scl_in, sda_in,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_nack, busy, scl_oe, sda_oe
    );

    modport slave (
        output cmd_valid, cmd_rw, cmd_reg, cmd_wdata, scl_in, sda_in,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_nack, busy, scl_oe, sda_oe
    );
endinterface

// File: rtl/i2c_master_ctrl.sv
// Single-target I2C register read/write master with quarter-bit tick timing.
// Optional SCL clock stretching is enabled by defining I2C_MASTER_CLKSTRETCH_EN.
module i2c_master_ctrl #(
    parameter logic [6:0]  DEVICE_ADDR = 7'b0101010,
    parameter int unsigned CLK_DIV     = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    i2c_master_ctrl_if.master  bus,
    output logic [2:0]         dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_SEND_BYTE,
        S_ACK_RX,
        S_RSTART,
        S_RECV_BYTE,
        S_ACK_TX,
        S_STOP
    } state_t;

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    state_t     state_q, state_d;
    logic [7:0] div_q, div_d;
    logic [1:0] tick_q, tick_d;
    logic [2:0] bit_q, bit_d;
    logic [1:0] byte_q, byte_d;
    logic [7:0] tx_q, tx_d;
    logic [7:0] rx_q, rx_d;
    logic       rw_q, rw_d;
    logic [3:0] reg_q, reg_d;
    logic [7:0] wdata_q, wdata_d;
    logic       ack_q, ack_d;
    logic       nack_q, nack_d;
    logic       rsp_valid_q, rsp_valid_d;
    logic [7:0] rsp_rdata_q, rsp_rdata_d;
    logic       rsp_nack_q, rsp_nack_d;

    logic hold;
    logic tick_end;
    logic bit_end;
    logic sample;

`ifdef I2C_MASTER_CLKSTRETCH_EN
    // While SCL is released (ticks 2-3) a target holding it low freezes the bit timing.
    assign hold = (state_q != S_IDLE) && tick_q[1] && !bus.scl_in;
`else
    logic unused_scl_in;
    assign unused_scl_in = bus.scl_in;
    assign hold          = 1'b0;
`endif

    assign tick_end = (div_q == DIV_LAST) && !hold;
    assign bit_end  = tick_end && (tick_q == 2'd3);
    assign sample   = tick_end && (tick_q == 2'd2);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            div_q       <= '0;
            tick_q      <= '0;
            bit_q       <= '0;
            byte_q      <= '0;
            tx_q        <= '0;
            rx_q        <= '0;
            rw_q        <= 1'b0;
            reg_q       <= '0;
            wdata_q     <= '0;
            ack_q       <= 1'b0;
            nack_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_nack_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            tick_q      <= tick_d;
            bit_q       <= bit_d;
            byte_q      <= byte_d;
            tx_q        <= tx_d;
            rx_q        <= rx_d;
            rw_q        <= rw_d;
            reg_q       <= reg_d;
            wdata_q     <= wdata_d;
            ack_q       <= ack_d;
            nack_q      <= nack_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_nack_q  <= rsp_nack_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        div_d       = div_q;
        tick_d      = tick_q;
        bit_d       = bit_q;
        byte_d      = byte_q;
        tx_d        = tx_q;
        rx_d        = rx_q;
        rw_d        = rw_q;
        reg_d       = reg_q;
        wdata_d     = wdata_q;
        ack_d       = ack_q;
        nack_d      = nack_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_nack_d  = rsp_nack_q;

        if (state_q != S_IDLE && !hold) begin
            if (tick_end) begin
                div_d  = '0;
                tick_d = tick_q + 2'd1;
            end else begin
                div_d = div_q + 8'd1;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (bus.cmd_valid) begin
                    state_d = S_START;
                    rw_d    = bus.cmd_rw;
                    reg_d   = bus.cmd_reg;
                    wdata_d = bus.cmd_wdata;
                    tx_d    = {DEVICE_ADDR, 1'b0};
                    byte_d  = 2'd0;
                    bit_d   = 3'd0;
                    nack_d  = 1'b0;
                    div_d   = '0;
                    tick_d  = '0;
                end
            end
            S_START: begin
                if (bit_end) state_d = S_SEND_BYTE;
            end
            S_SEND_BYTE: begin
                if (bit_end) begin
                    if (bit_q == 3'd7) begin
                        state_d = S_ACK_RX;
                        bit_d   = 3'd0;
                    end else begin
                        bit_d = bit_q + 3'd1;
                        tx_d  = {tx_q[6:0], 1'b0};
                    end
                end
            end
            S_ACK_RX: begin
                if (sample) ack_d = bus.sda_in;
                if (bit_end) begin
                    if (ack_q) begin
                        nack_d  = 1'b1;
                        state_d = S_STOP;
                    end else begin
                        // byte_q: 0 = write address, 1 = register index, 2 = data or read address
                        case (byte_q)
                            2'd0: begin
                                tx_d    = {4'h0, reg_q};
                                byte_d  = 2'd1;
                                state_d = S_SEND_BYTE;
                            end
                            2'd1: begin
                                if (rw_q) begin
                                    state_d = S_RSTART;
                                end else begin
                                    tx_d    = wdata_q;
                                    byte_d  = 2'd2;
                                    state_d = S_SEND_BYTE;
                                end
                            end
                            default: state_d = rw_q ? S_RECV_BYTE : S_STOP;
                        endcase
                    end
                end
            end
            S_RSTART: begin
                if (bit_end) begin
                    tx_d    = {DEVICE_ADDR, 1'b1};
                    byte_d  = 2'd2;
                    state_d = S_SEND_BYTE;
                end
            end
            S_RECV_BYTE: begin
                if (sample) rx_d = {rx_q[6:0], bus.sda_in};
                if (bit_end) begin
                    if (bit_q == 3'd7) begin
                        state_d = S_ACK_TX;
                        bit_d   = 3'd0;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            S_ACK_TX: begin
                if (bit_end) state_d = S_STOP;
            end
            S_STOP: begin
                if (bit_end) begin
                    state_d     = S_IDLE;
                    rsp_valid_d = 1'b1;
                    rsp_nack_d  = nack_q;
                    rsp_rdata_d = (rw_q && !nack_q) ? rx_q : 8'h00;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Bus drive decode. RSTART pulls SCL low first so the target can release its ACK,
    // and STOP lowers SDA under a low SCL before releasing SDA with SCL high.
    always_comb begin
        bus.scl_oe = 1'b0;
        bus.sda_oe = 1'b0;
        case (state_q)
            S_START: begin
                bus.sda_oe = tick_q[1];
            end
            S_RSTART: begin
                bus.scl_oe = (tick_q == 2'd0);
                bus.sda_oe = tick_q[1];
            end
            S_SEND_BYTE: begin
                bus.scl_oe = !tick_q[1];
                bus.sda_oe = !tx_q[7];
            end
            S_ACK_RX, S_RECV_BYTE, S_ACK_TX: begin
                bus.scl_oe = !tick_q[1];
            end
            S_STOP: begin
                bus.scl_oe = !tick_q[1];
                bus.sda_oe = (tick_q == 2'd1) || (tick_q == 2'd2);
            end
            default: begin
                bus.scl_oe = 1'b0;
                bus.sda_oe = 1'b0;
            end
        endcase
    end

    assign bus.cmd_ready = (state_q == S_IDLE);
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_nack  = rsp_nack_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_i2c_master_ctrl.sv
// Directed bench for i2c_master_ctrl: vector table plus reset, back-to-back and stretch sequences.
// A behavioural I2C target logs bus events into a scoreboard fed with hand-written expectations.
module tb_i2c_master_ctrl;

  localparam int LAT_LIMIT = 3000;
  localparam logic [9:0] EV_START = 10'h100;
  localparam logic [9:0] EV_STOP  = 10'h200;
  localparam logic [9:0] EV_MACK  = 10'h300;

  logic       clk;
  logic       rst_n;
  logic [2:0] dbg_state;
  logic       stretch;
  logic       tgt_sda_low;
  logic       tgt_present;
  logic [7:0] tgt_data;
  logic       bus_scl;
  logic       bus_sda;

  int checks;
  int errors;
  logic [9:0] exp_q[$];

  i2c_master_ctrl_if bus_if ();

  i2c_master_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus_if),
    .dbg_state (dbg_state)
  );

  assign bus_scl       = !bus_if.scl_oe && !stretch;
  assign bus_sda       = !bus_if.sda_oe && !tgt_sda_low;
  assign bus_if.scl_in = bus_scl;
  assign bus_if.sda_in = bus_sda;

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic log_event(input logic [9:0] ev);
    logic [9:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL bus_event got %0h expected none", ev);
    end else begin
      e = exp_q.pop_front();
      if (ev !== e) begin
        errors++;
        $display("FAIL bus_event got %0h expected %0h", ev, e);
      end
    end
  endtask

  // behavioural target: ACKs address 7'h2A when present, returns tgt_data on reads
  typedef enum int {P_WAIT, P_RX, P_ACKP, P_ACKS, P_TX, P_MACK} phase_t;
  phase_t     phase;
  logic       prev_scl;
  logic       prev_sda;
  logic [7:0] sh;
  int         bcnt;
  int         txc;
  logic       first;
  logic       read_mode;

  always @(negedge clk) begin
    logic scl;
    logic sda;
    scl = bus_scl;
    sda = bus_sda;
    if (!rst_n) begin
      phase       = P_WAIT;
      tgt_sda_low = 1'b0;
    end else if (prev_scl && scl && prev_sda && !sda) begin
      log_event(EV_START);
      phase       = P_RX;
      bcnt        = 0;
      first       = 1'b1;
      tgt_sda_low = 1'b0;
    end else if (prev_scl && scl && !prev_sda && sda) begin
      log_event(EV_STOP);
      phase       = P_WAIT;
      tgt_sda_low = 1'b0;
    end else if (!prev_scl && scl) begin
      if (phase == P_RX || phase == P_TX) begin
        sh = {sh[6:0], sda};
        bcnt++;
        if (bcnt == 8) begin
          log_event({2'b00, sh});
          if (phase == P_RX) phase = P_ACKP;
        end
      end else if (phase == P_MACK) begin
        log_event(EV_MACK | {9'd0, sda});
        phase = P_WAIT;
      end
    end else if (prev_scl && !scl) begin
      case (phase)
        P_ACKP: begin
          if (tgt_present && (!first || sh[7:1] == 7'h2A)) begin
            tgt_sda_low = 1'b1;
            if (first) read_mode = sh[0];
            phase = P_ACKS;
          end else begin
            phase = P_WAIT;
          end
        end
        P_ACKS: begin
          tgt_sda_low = 1'b0;
          bcnt        = 0;
          if (first && read_mode) begin
            phase       = P_TX;
            tgt_sda_low = !tgt_data[7];
            txc         = 1;
          end else begin
            phase = P_RX;
          end
          first = 1'b0;
        end
        P_TX: begin
          if (txc == 8) begin
            tgt_sda_low = 1'b0;
            phase       = P_MACK;
          end else begin
            tgt_sda_low = !tgt_data[7-txc];
            txc++;
          end
        end
        default: ;
      endcase
    end
    prev_scl = bus_scl;
    prev_sda = bus_sda;
  end

  // expected bus events for one transaction
  task automatic push_txn(input logic rw, input logic [3:0] rg, input logic [7:0] wd,
                          input logic present, input logic [7:0] td);
    exp_q.push_back(EV_START);
    exp_q.push_back(10'h054);
    if (!present) begin
      exp_q.push_back(EV_STOP);
    end else if (!rw) begin
      exp_q.push_back({6'd0, rg});
      exp_q.push_back({2'b00, wd});
      exp_q.push_back(EV_STOP);
    end else begin
      exp_q.push_back({6'd0, rg});
      exp_q.push_back(EV_START);
      exp_q.push_back(10'h055);
      exp_q.push_back({2'b00, td});
      exp_q.push_back(EV_MACK | 10'd1);
      exp_q.push_back(EV_STOP);
    end
  endtask

  // driver: present a command and return #1 after the accepting edge (cmd_valid left high)
  task automatic start_cmd(input logic rw, input logic [3:0] rg, input logic [7:0] wd);
    @(negedge clk);
    bus_if.cmd_rw    = rw;
    bus_if.cmd_reg   = rg;
    bus_if.cmd_wdata = wd;
    bus_if.cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    check("accept_busy", bus_if.busy, 1);
    check("accept_ready", bus_if.cmd_ready, 0);
  endtask

  // lat counts edges from the accepting edge to the edge that first samples rsp_valid high
  task automatic wait_rsp(input int exp_lat, input logic exp_nack, input logic chk_rd,
                          input logic [7:0] exp_rd);
    int lat;
    bit seen;
    lat  = 1;
    seen = 0;
    while (!seen && lat < LAT_LIMIT) begin
      if (bus_if.rsp_valid) begin
        seen = 1;
      end else begin
        @(posedge clk);
        #1;
        lat++;
      end
    end
    check("rsp_seen", seen, 1);
    check("rsp_latency", lat, exp_lat);
    check("rsp_nack", bus_if.rsp_nack, exp_nack);
    check("rsp_done_ready", bus_if.cmd_ready, 1);
    if (chk_rd) check("rsp_rdata", bus_if.rsp_rdata, exp_rd);
  endtask

  task automatic after_rsp(input logic chk_rd, input logic [7:0] exp_rd, input logic exp_nack);
    @(posedge clk);
    #1;
    check("rsp_pulse", bus_if.rsp_valid, 0);
    check("hold_nack", bus_if.rsp_nack, exp_nack);
    if (chk_rd) check("hold_rdata", bus_if.rsp_rdata, exp_rd);
    check("bus_done", exp_q.size(), 0);
  endtask

  typedef struct {
    logic       rw;
    logic [3:0] rg;
    logic [7:0] wd;
    logic       present;
    logic [7:0] tdata;
    logic       exp_nack;
    logic [7:0] exp_rd;
    int         exp_lat;
  } vec_t;

  vec_t vecs[6];

  initial begin
    vecs[0] = '{rw: 1'b0, rg: 4'h3, wd: 8'hA5, present: 1'b1, tdata: 8'h00, exp_nack: 1'b0, exp_rd: 8'h00, exp_lat: 465};
    vecs[1] = '{rw: 1'b1, rg: 4'h7, wd: 8'h00, present: 1'b1, tdata: 8'h3C, exp_nack: 1'b0, exp_rd: 8'h3C, exp_lat: 625};
    vecs[2] = '{rw: 1'b1, rg: 4'h9, wd: 8'h00, present: 1'b0, tdata: 8'hFF, exp_nack: 1'b1, exp_rd: 8'h00, exp_lat: 177};
    vecs[3] = '{rw: 1'b0, rg: 4'h5, wd: 8'h5A, present: 1'b0, tdata: 8'h00, exp_nack: 1'b1, exp_rd: 8'h00, exp_lat: 177};
    vecs[4] = '{rw: 1'b0, rg: 4'hF, wd: 8'h5A, present: 1'b1, tdata: 8'h00, exp_nack: 1'b0, exp_rd: 8'h00, exp_lat: 465};
    vecs[5] = '{rw: 1'b1, rg: 4'h0, wd: 8'h00, present: 1'b1, tdata: 8'hC3, exp_nack: 1'b0, exp_rd: 8'hC3, exp_lat: 625};

    checks           = 0;
    errors           = 0;
    rst_n            = 1'b0;
    stretch          = 1'b0;
    tgt_sda_low      = 1'b0;
    tgt_present      = 1'b1;
    tgt_data         = 8'h00;
    prev_scl         = 1'b1;
    prev_sda         = 1'b1;
    phase            = P_WAIT;
    sh               = 8'h00;
    bcnt             = 0;
    txc              = 0;
    first            = 1'b0;
    read_mode        = 1'b0;
    bus_if.cmd_valid = 1'b0;
    bus_if.cmd_rw    = 1'b0;
    bus_if.cmd_reg   = 4'h0;
    bus_if.cmd_wdata = 8'h00;

    repeat (3) @(posedge clk);
    #1;
    check("rst_scl_oe", bus_if.scl_oe, 0);
    check("rst_sda_oe", bus_if.sda_oe, 0);
    check("rst_ready", bus_if.cmd_ready, 1);
    check("rst_busy", bus_if.busy, 0);
    check("rst_rsp_valid", bus_if.rsp_valid, 0);
    check("rst_rdata", bus_if.rsp_rdata, 8'h00);
    check("rst_nack", bus_if.rsp_nack, 0);
    check("rst_state", dbg_state, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // vector table
    for (int i = 0; i < 6; i++) begin
      tgt_present = vecs[i].present;
      tgt_data    = vecs[i].tdata;
      push_txn(vecs[i].rw, vecs[i].rg, vecs[i].wd, vecs[i].present, vecs[i].tdata);
      start_cmd(vecs[i].rw, vecs[i].rg, vecs[i].wd);
      bus_if.cmd_valid = 1'b0;
      wait_rsp(vecs[i].exp_lat, vecs[i].exp_nack, vecs[i].rw || vecs[i].exp_nack, vecs[i].exp_rd);
      after_rsp(vecs[i].rw || vecs[i].exp_nack, vecs[i].exp_rd, vecs[i].exp_nack);
    end

    // reset during bit 4 of the register byte (tick 56 spans edges 224..227)
    tgt_present = 1'b1;
    exp_q.push_back(EV_START);
    exp_q.push_back(10'h054);
    start_cmd(1'b0, 4'h3, 8'hA5);
    bus_if.cmd_valid = 1'b0;
    repeat (225) @(posedge clk);
    #1;
    check("pre_rst_scl_oe", bus_if.scl_oe, 1);
    check("pre_rst_sda_oe", bus_if.sda_oe, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_scl_oe", bus_if.scl_oe, 0);
    check("mid_rst_sda_oe", bus_if.sda_oe, 0);
    check("mid_rst_ready", bus_if.cmd_ready, 1);
    check("mid_rst_busy", bus_if.busy, 0);
    check("mid_rst_rsp_valid", bus_if.rsp_valid, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    begin
      bit pulsed;
      pulsed = 0;
      repeat (40) begin
        @(negedge clk);
        if (bus_if.rsp_valid) pulsed = 1;
      end
      check("abort_no_rsp", pulsed, 0);
    end
    check("abort_bus", exp_q.size(), 0);
    push_txn(1'b0, 4'h3, 8'hA5, 1'b1, 8'h00);
    start_cmd(1'b0, 4'h3, 8'hA5);
    bus_if.cmd_valid = 1'b0;
    wait_rsp(465, 1'b0, 1'b0, 8'h00);
    after_rsp(1'b0, 8'h00, 1'b0);

    // back-to-back writes with cmd_valid held high; changed fields while busy are ignored
    push_txn(1'b0, 4'h3, 8'hA5, 1'b1, 8'h00);
    push_txn(1'b0, 4'hC, 8'h81, 1'b1, 8'h00);
    start_cmd(1'b0, 4'h3, 8'hA5);
    bus_if.cmd_reg   = 4'hC;
    bus_if.cmd_wdata = 8'h81;
    repeat (50) @(posedge clk);
    #1;
    check("busy_ignore_ready", bus_if.cmd_ready, 0);
    // re-enter the latency count after the 50 edges already waited
    begin
      int lat;
      lat = 51;
      while (!bus_if.rsp_valid && lat < LAT_LIMIT) begin
        @(posedge clk);
        #1;
        lat++;
      end
      check("b2b_first_latency", lat, 465);
      check("b2b_first_ready", bus_if.cmd_ready, 1);
    end
    @(posedge clk);
    #1;
    bus_if.cmd_valid = 1'b0;
    check("b2b_second_busy", bus_if.busy, 1);
    check("b2b_second_rsp_low", bus_if.rsp_valid, 0);
    wait_rsp(465, 1'b0, 1'b0, 8'h00);
    after_rsp(1'b0, 8'h00, 1'b0);

`ifdef I2C_MASTER_CLKSTRETCH_EN
    // target holds SCL low for 10 clocks on bit 2 of the data byte (tick 86 starts after edge 344)
    push_txn(1'b0, 4'h3, 8'hA5, 1'b1, 8'h00);
    start_cmd(1'b0, 4'h3, 8'hA5);
    bus_if.cmd_valid = 1'b0;
    repeat (343) @(posedge clk);
    @(negedge clk);
    stretch = 1'b1;
    repeat (11) @(negedge clk);
    stretch = 1'b0;
    begin
      int lat;
      lat = 355;
      while (!bus_if.rsp_valid && lat < LAT_LIMIT) begin
        @(posedge clk);
        #1;
        lat++;
      end
      check("stretch_latency", lat, 475);
      check("stretch_nack", bus_if.rsp_nack, 0);
    end
    after_rsp(1'b0, 8'h00, 1'b0);
`endif

    repeat (5) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2c_master_ctrl.md
I2C_MASTER_CTRL -- requirements
Module: i2c_master_ctrl

Interface
REQ-001 Parameter DEVICE_ADDR, default 7'b0101010: 7-bit target address sent in every address byte.
REQ-002 Parameter CLK_DIV, default 4, legal range 1..255: clk cycles per quarter-bit tick.
REQ-003 clk  in  1  single clock; all state on rising edge.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 cmd_valid  in  1  command request.
REQ-006 cmd_ready  out  1  high when a command can be accepted.
REQ-007 cmd_rw  in  1  1=register read, 0=register write.
REQ-008 cmd_reg  in  4  target register index.
REQ-009 cmd_wdata  in  8  write data.
REQ-010 rsp_valid  out  1  one-cycle completion pulse.
REQ-011 rsp_rdata  out  8  read data, valid with rsp_valid.
REQ-012 rsp_nack  out  1  1=target NACKed, valid with rsp_valid.
REQ-013 busy  out  1  transaction in progress.
REQ-014 scl_in, sda_in  in  1 each  sampled bus levels.
REQ-015 scl_oe, sda_oe  out  1 each  open-drain pull-low enables; 1 drives 0, 0 releases.

Function
REQ-016 Accept = cmd_valid & cmd_ready; latch cmd_rw/cmd_reg/cmd_wdata on that edge; cmd_ready low and busy high from the next cycle.
REQ-017 Bit period = 4 ticks: SCL low ticks 0-1, released ticks 2-3; SDA changes only at start of tick 0; SDA sampled at end of tick 2.
REQ-018 States: IDLE, START, SEND_BYTE, ACK_RX, RSTART, RECV_BYTE, ACK_TX, STOP; bytes sent MSB first with a 3-bit bit counter.
REQ-019 START/RSTART: SDA high to low while SCL released, 4 ticks; STOP: SDA low to high while SCL released, 4 ticks.
REQ-020 Write sequence: START, {DEVICE_ADDR,0}, ACK, {4'h0,cmd_reg}, ACK, cmd_wdata, ACK, STOP.
REQ-021 Read sequence: START, {DEVICE_ADDR,0}, ACK, {4'h0,cmd_reg}, ACK, RSTART, {DEVICE_ADDR,1}, ACK, 8 bits received, master NACK (SDA released), STOP.
REQ-022 ACK_RX samples sda_in; 1 = NACK: go directly to STOP, skip remaining bytes, rsp_nack=1, rsp_rdata=8'h00.
REQ-023 rsp_valid pulses the cycle after the STOP tick ends; cmd_ready and busy=0 take effect the same cycle; a command presented in that cycle is accepted.
REQ-024 Latency, acceptance to rsp_valid: write 116*CLK_DIV+1 clocks; read 156*CLK_DIV+1 clocks (no stretching, no NACK).
REQ-025 rsp_rdata and rsp_nack hold their values until the next rsp_valid.
REQ-026 cmd_valid while busy is ignored; no queuing.

Reset
REQ-027 rst_n low: immediately scl_oe=0, sda_oe=0, cmd_ready=1, busy=0, rsp_valid=0, rsp_rdata=8'h00, rsp_nack=0, state IDLE, counters 0.
REQ-028 Reset mid-transaction releases the bus with no STOP and no rsp_valid; the latched command is discarded.

Configuration
REQ-029 Macro I2C_MASTER_CLKSTRETCH_EN defined: during ticks 2-3 the tick counter holds while scl_in=0 (target stretch); the bit resumes when scl_in=1.
REQ-030 Macro undefined: scl_in ignored (port kept, unused); timing is exactly REQ-024.

Verification
REQ-031 Write reg 3, data 0xA5, ACKing target model: bus bytes 0x54,0x03,0xA5 then STOP; rsp_valid at 465 clocks (CLK_DIV=4); rsp_nack=0.
REQ-032 Read reg 7, target returns 0x3C: bytes 0x54,0x07, RSTART, 0x55, data 0x3C, master NACK, STOP; rsp_rdata=0x3C, rsp_nack=0.
REQ-033 No target (SDA never pulled low): NACK after 0x54, STOP follows immediately; rsp_nack=1, rsp_rdata=0x00.
REQ-034 rst_n low during bit 4 of the register byte: scl_oe=sda_oe=0 same cycle, no rsp_valid, cmd_ready=1; a subsequent write completes correctly.
REQ-035 With I2C_MASTER_CLKSTRETCH_EN, target holds SCL low 10 clocks on bit 2 of the data byte: high phase extended by 10 clocks, bytes intact, rsp_valid 10 clocks later than REQ-031.
REQ-036 cmd_valid held high for two writes back-to-back: second accepted in the rsp_valid cycle of the first; the STOP of the first precedes the START of the second; cmd_valid during busy is not accepted.
